// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle RV32I control unit (fetch/decode/exec/mem/wb) with sticky trap flags.
// Optional MC_MULDIV_EN: accepts R-type funct7=0000001 and sequences an external mul/div unit.
module mc_ctrl #(
  parameter int ALU_OP_W = 4,
  parameter int TO_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                md_done,
  output logic                imem_req,
  output logic                ir_we,
  output logic                pc_we,
  output logic [2:0]          sext_op,
  output logic                alu_a_sel,
  output logic                alu_b_sel,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          wd_sel,
  output logic                rf_we,
  output logic [1:0]          store_op,
  output logic [2:0]          load_op,
  output logic                dram_req,
  output logic                dram_we,
  output logic                branch,
  output logic [1:0]          npc_op,
  output logic                md_start,
  output logic [2:0]          md_op,
  output logic                illegal,
  output logic                timeout_err,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5,
    S_MULDIV = 3'd6
  } state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
`ifdef MC_MULDIV_EN
  localparam logic [6:0] F7_MD   = 7'b0000001;
`endif

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_BEQ  = 4'b1010;
  localparam logic [3:0] ALU_BNE  = 4'b1011;
  localparam logic [3:0] ALU_BGE  = 4'b1100;
  localparam logic [3:0] ALU_BGEU = 4'b1101;
  localparam logic [3:0] ALU_LUI  = 4'b1110;

  localparam logic [2:0] SX_I = 3'b000, SX_SHAMT = 3'b001, SX_S = 3'b010;
  localparam logic [2:0] SX_B = 3'b011, SX_U = 3'b100, SX_J = 3'b101;
  localparam logic [1:0] WD_ALU = 2'b00, WD_DRAM = 2'b01, WD_PC4 = 2'b10;
  localparam logic [1:0] NPC_PC4 = 2'b00, NPC_JALR = 2'b01, NPC_BR = 2'b10, NPC_JAL = 2'b11;

  // Terminal count: the MEM cycle in which the counter would reach 2^TO_W-1.
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  state_e          state_q, state_d;
  logic [31:0]     ir_q, ir_d;
  logic            illegal_q, illegal_d;
  logic            tmo_q, tmo_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       dec_ill, dec_load, dec_store, dec_branch, dec_md;
  logic [2:0] dec_sext, dec_lop;
  logic [3:0] dec_alu;
  logic [1:0] dec_wd, dec_npc, dec_sop;
  logic       dec_asel, dec_bsel;

  assign opc = ir_q[6:0];
  assign f3  = ir_q[14:12];
  assign f7  = ir_q[31:25];

  function automatic logic [3:0] alu_f3(input logic [2:0] fn3, input logic alt);
    logic [3:0] r;
    case (fn3)
      3'b000:  r = alt ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  // Decode is purely a function of IR, which only changes on a fetch, so the
  // fields are stable from DECODE through WB.
  always_comb begin
    dec_ill    = 1'b0;
    dec_load   = 1'b0;
    dec_store  = 1'b0;
    dec_branch = 1'b0;
    dec_md     = 1'b0;
    dec_sext   = SX_I;
    dec_alu    = ALU_ADD;
    dec_wd     = WD_ALU;
    dec_npc    = NPC_PC4;
    dec_lop    = 3'b000;
    dec_sop    = 2'b00;
    dec_asel   = 1'b0;
    dec_bsel   = 1'b0;
    case (opc)
      OPC_LUI: begin
        dec_sext = SX_U;
        dec_alu  = ALU_LUI;
        dec_bsel = 1'b1;
      end
      OPC_AUIPC: begin
        dec_sext = SX_U;
        dec_asel = 1'b1;
        dec_bsel = 1'b1;
      end
      OPC_JAL: begin
        dec_sext = SX_J;
        dec_wd   = WD_PC4;
        dec_npc  = NPC_JAL;
      end
      OPC_JALR: begin
        dec_bsel = 1'b1;
        dec_wd   = WD_PC4;
        dec_npc  = NPC_JALR;
        dec_ill  = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec_branch = 1'b1;
        dec_sext   = SX_B;
        dec_npc    = NPC_BR;
        case (f3)
          3'b000:  dec_alu = ALU_BEQ;
          3'b001:  dec_alu = ALU_BNE;
          3'b100:  dec_alu = ALU_SLT;
          3'b101:  dec_alu = ALU_BGE;
          3'b110:  dec_alu = ALU_SLTU;
          3'b111:  dec_alu = ALU_BGEU;
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec_load = 1'b1;
        dec_bsel = 1'b1;
        dec_wd   = WD_DRAM;
        case (f3)
          3'b000:  dec_lop = 3'b000;
          3'b100:  dec_lop = 3'b001;
          3'b001:  dec_lop = 3'b010;
          3'b101:  dec_lop = 3'b011;
          3'b010:  dec_lop = 3'b100;
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec_store = 1'b1;
        dec_sext  = SX_S;
        dec_bsel  = 1'b1;
        case (f3)
          3'b000:  dec_sop = 2'b00;
          3'b001:  dec_sop = 2'b01;
          3'b010:  dec_sop = 2'b10;
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_IMM: begin
        dec_bsel = 1'b1;
        dec_alu  = alu_f3(f3, 1'b0);
        // Only shift-immediates carry a funct7; elsewhere those bits are immediate.
        if (f3 == 3'b001) begin
          dec_sext = SX_SHAMT;
          dec_ill  = (f7 != F7_BASE);
        end else if (f3 == 3'b101) begin
          dec_sext = SX_SHAMT;
          dec_alu  = alu_f3(f3, f7 == F7_ALT);
          dec_ill  = (f7 != F7_BASE) && (f7 != F7_ALT);
        end
      end
      OPC_OP: begin
        if (f7 == F7_BASE)
          dec_alu = alu_f3(f3, 1'b0);
        else if ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)))
          dec_alu = alu_f3(f3, 1'b1);
`ifdef MC_MULDIV_EN
        else if (f7 == F7_MD)
          dec_md = 1'b1;
`endif
        else
          dec_ill = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ir_q      <= 32'h0000_0013;
      illegal_q <= 1'b0;
      tmo_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef MC_MULDIV_EN
  logic md_start_q, md_start_d;
  always_ff @(posedge clk) begin
    if (rst) md_start_q <= 1'b0;
    else     md_start_q <= md_start_d;
  end
  assign md_start = md_start_q;
  assign md_op    = f3;
`else
  logic md_unused;
  assign md_unused = md_done;
  assign md_start  = 1'b0;
  assign md_op     = 3'b000;
`endif

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
`ifdef MC_MULDIV_EN
    md_start_d = 1'b0;
`endif
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    dram_req  = 1'b0;
    dram_we   = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_ill) begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (dec_load || dec_store) begin
          cnt_d   = '0;
          state_d = S_MEM;
        end else if (dec_branch) begin
          pc_we   = 1'b1;
          state_d = S_FETCH;
`ifdef MC_MULDIV_EN
        end else if (dec_md) begin
          md_start_d = 1'b1;
          state_d    = S_MULDIV;
`endif
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dram_req = 1'b1;
        dram_we  = dec_store;
        // A response on the terminal cycle still wins over the timeout.
        if (dmem_ready) begin
          if (dec_store) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == TO_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
`ifdef MC_MULDIV_EN
      S_MULDIV: if (md_done) state_d = S_WB;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  logic ir_unused;
  assign ir_unused = ^{ir_q[24:15], ir_q[11:7], dec_md};

  assign state       = state_q;
  assign illegal     = illegal_q;
  assign timeout_err = tmo_q;
  assign sext_op     = dec_sext;
  assign alu_a_sel   = dec_asel;
  assign alu_b_sel   = dec_bsel;
  assign alu_op      = ALU_OP_W'(dec_alu);
  assign wd_sel      = dec_wd;
  assign store_op    = dec_sop;
  assign load_op     = dec_lop;
  assign branch      = dec_branch;
  assign npc_op      = dec_npc;

endmodule
